mem_ctrl: RTL

//  CPU-side memory controller that owns the core's 8-bit external bus (mem_a/mem_wr/mem_dout/mem_din).

---
 rtl/mem_ctrl_if.sv | 51 +++++
 rtl/mem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//   Request/response handshake between the CPU-side requesters (instruction
//   fetch unit and load/store buffer) and the memory controller.
//
//   Fetch side
//     if_req    requester -> ctrl   fetch request, held until if_done
//     if_addr   requester -> ctrl   fetch address (4 bytes, little-endian)
//     if_flush  requester -> ctrl   cancel any fetch in flight
//     if_done   ctrl -> requester   1-cycle pulse, if_data valid
//     if_data   ctrl -> requester   fetched word
//   Load/store side
//     ls_req    requester -> ctrl   request, held until ls_done
//     ls_wr     requester -> ctrl   1 = store
//     ls_size   requester -> ctrl   0 byte, 1 half, 2/3 word
//     ls_addr   requester -> ctrl   first byte address
//     ls_wdata  requester -> ctrl   store data, byte 0 written first
//     ls_done   ctrl -> requester   1-cycle pulse
//     ls_rdata  ctrl -> requester   load data, zero-extended
//
//   Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_flush;
   logic                  if_done;
   logic [31:0]           if_data;

   logic                  ls_req;
   logic                  ls_wr;
   logic [1:0]            ls_size;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [31:0]           ls_wdata;
   logic                  ls_done;
   logic [31:0]           ls_rdata;

   modport master (
      output if_req, if_addr, if_flush,
      output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
      input  if_done, if_data, ls_done, ls_rdata
   );

   modport slave (
      input  if_req, if_addr, if_flush,
      input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
      output if_done, if_data, ls_done, ls_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   CPU-side memory controller owning the core's 8-bit external bus.
//   Serialises 32-bit instruction fetches and 1/2/4-byte loads/stores into
//   byte accesses on a synchronous single-port RAM (1-cycle read latency) and
//   the memory-mapped IO window (addr[IO_HI_BIT:IO_HI_BIT-1] == 2'b11).
//
//   Ports
//     clk_in          in   clock, all logic on posedge
//     rst_n_in        in   asynchronous active-low reset
//     rdy_in          in   0 = bus owned by HCI, controller frozen
//     io_buffer_full  in   UART tx buffer full, blocks IO writes
//     mem_din         in   read byte, valid 1 cycle after address
//     mem_dout        out  write byte
//     mem_a           out  byte address (holds last value when idle)
//     mem_wr          out  1 = write this cycle
//     req_if          slave modport of mem_ctrl_if (fetch + load/store)
//
//   Optional feature: define MEM_CTRL_PERF_EN to add
//     perf_busy   out  cycles spent outside IDLE with rdy_in=1
//     perf_stall  out  cycles blocked by rdy_in=0 or io_buffer_full
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int IO_HI_BIT  = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  io_buffer_full,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   mem_ctrl_if.slave             req_if
`ifdef MEM_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_busy,
   output logic [31:0]           perf_stall
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [2:0]            nbytes_q, nbytes_d;
   logic [2:0]            iss_q, iss_d;      // next byte to issue / write
   logic [2:0]            cap_q, cap_d;      // next byte to capture
   logic                  vld_q, vld_d;      // a read was issued last active cycle
   logic                  stall_q;           // rdy_in was low last cycle
   logic                  owner_ls_q, owner_ls_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           buf_q, buf_d;
   logic [31:0]           if_data_q, if_data_d;
   logic [31:0]           ls_rdata_q, ls_rdata_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  wr_d;
   logic                  io_block;
   logic                  if_done_d;
   logic                  ls_done_d;

   function automatic logic [2:0] size_to_n(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign cur_addr = base_q + ADDR_WIDTH'(iss_q);

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      nbytes_d   = nbytes_q;
      iss_d      = iss_q;
      cap_d      = cap_q;
      vld_d      = vld_q;
      owner_ls_d = owner_ls_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      wr_d       = 1'b0;
      io_block   = 1'b0;

      // Done is decoded from the frozen state, so a stall inside DONE holds it
      // together with the rest of the core.
      ls_done_d = (state_q == ST_DONE) && owner_ls_q;
      if_done_d = (state_q == ST_DONE) && !owner_ls_q && !req_if.if_flush;

      if (rdy_in) begin
         case (state_q)
            ST_IDLE: begin
               iss_d = '0;
               cap_d = '0;
               vld_d = 1'b0;
               buf_d = '0;
               if (req_if.ls_req) begin
                  base_d     = req_if.ls_addr;
                  nbytes_d   = size_to_n(req_if.ls_size);
                  owner_ls_d = 1'b1;
                  wdata_d    = req_if.ls_wdata;
                  state_d    = req_if.ls_wr ? ST_WRITE : ST_READ;
               end else if (req_if.if_req) begin
                  base_d     = req_if.if_addr;
                  nbytes_d   = 3'd4;
                  owner_ls_d = 1'b0;
                  state_d    = ST_READ;
               end
            end

            ST_READ: begin
               if (!owner_ls_q && req_if.if_flush) begin
                  vld_d   = 1'b0;
                  state_d = ST_IDLE;
               end else if (stall_q) begin
                  // mem_din is not trusted after a stall: re-issue the first
                  // uncaptured byte and resume the pipeline from there.
                  mem_a_d = base_q + ADDR_WIDTH'(cap_q);
                  iss_d   = cap_q + 3'd1;
                  vld_d   = 1'b1;
               end else begin
                  if (vld_q) begin
                     buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                     cap_d = cap_q + 3'd1;
                  end
                  if (iss_q < nbytes_q) begin
                     mem_a_d = cur_addr;
                     iss_d   = iss_q + 3'd1;
                     vld_d   = 1'b1;
                  end else begin
                     vld_d = 1'b0;
                  end
                  if (vld_q && (cap_q == 3'(nbytes_q - 3'd1))) begin
                     state_d = ST_DONE;
                     if (owner_ls_q) begin
                        ls_rdata_d = buf_d;
                     end else begin
                        if_data_d = buf_d;
                     end
                  end
               end
            end

            ST_WRITE: begin
               io_block   = (cur_addr[IO_HI_BIT -: 2] == 2'b11) && io_buffer_full;
               mem_a_d    = cur_addr;
               mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
               if (!io_block) begin
                  wr_d  = 1'b1;
                  iss_d = iss_q + 3'd1;
                  if (iss_q == 3'(nbytes_q - 3'd1)) begin
                     state_d = ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               state_d = ST_IDLE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         nbytes_q   <= '0;
         iss_q      <= '0;
         cap_q      <= '0;
         vld_q      <= 1'b0;
         stall_q    <= 1'b0;
         owner_ls_q <= 1'b0;
         wdata_q    <= '0;
         buf_q      <= '0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         nbytes_q   <= nbytes_d;
         iss_q      <= iss_d;
         cap_q      <= cap_d;
         vld_q      <= vld_d;
         stall_q    <= !rdy_in;
         owner_ls_q <= owner_ls_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
      end
   end

   assign mem_a           = mem_a_d;
   assign mem_dout        = mem_dout_d;
   assign mem_wr          = wr_d;
   assign req_if.if_done  = if_done_d;
   assign req_if.ls_done  = ls_done_d;
   assign req_if.if_data  = if_data_q;
   assign req_if.ls_rdata = ls_rdata_q;

`ifdef MEM_CTRL_PERF_EN
   logic [31:0] perf_busy_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (rdy_in && (state_q != ST_IDLE)) begin
            perf_busy_q <= perf_busy_q + 32'd1;
         end
         if ((!rdy_in && (state_q != ST_IDLE)) || io_block) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_busy  = perf_busy_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule
